hilo_mult_seq: RTL and testbench
================================

Name: hilo_mult_seq

Overview:
- Multi-cycle sequencer for MULT/MULTU, replacing the single-cycle HI/LO write path.
- Captures operands when the EX-stage control asserts enhilo_EX.
- Runs a radix-2 shift-add multiply over WIDTH cycles, then writes the HI/LO registers.
- Drives stall_FETCH to the control unit while a dependent instruction would read an incomplete result.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
enhilo_EX  input  1  start request; MULT/MULTU is in EX
is_signed  input  1  1 = MULT (two's complement), 0 = MULTU; sampled with enhilo_EX
regsel_EX  input  2  EX instruction selector; 1 = MFHI, 2 = MFLO, 0 = other
a  input  WIDTH  rs operand; sampled on start
b  input  WIDTH  rt operand; sampled on start
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
busy  output  1  multiply in progress
done  output  1  one-cycle pulse; HI/LO just updated
stall_FETCH  output  1  hold fetch and EX instruction

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE; hi = 0, lo = 0; busy = 0, done = 0.
  - Counter, multiplicand, accumulator and sign registers cleared.
- States: IDLE, CALC, FIX.
  - busy = 1 in CALC and FIX.
  - busy is registered-state decode, not a separate flop.
- IDLE:
  - On an edge with enhilo_EX = 1:
    - latch ma = |a| and mb = |b| when is_signed, else a and b unsigned.
    - latch neg = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]).
    - clear the 2*WIDTH accumulator, cnt = 0, go to CALC.
  - |x| of the most negative value is 2^(WIDTH-1), held unsigned; no overflow.
- CALC, one iteration per edge:
  - if mb[0], acc += ma shifted left by cnt.
  - mb >>= 1; cnt += 1.
  - Equivalent shift-register forms are allowed if the result is bit-identical.
  - On the edge where cnt == WIDTH-1 completes, go to FIX. This is exactly WIDTH edges in CALC.
- FIX, one edge:
  - {hi, lo} = neg ? -acc : acc, using 2*WIDTH two's-complement negate.
  - done = 1 for the following cycle; state = IDLE.
- Latency:
  - Start edge E0; HI/LO valid after edge E0 + WIDTH + 1 (E33 at default).
  - busy is high for WIDTH + 1 cycles.
- HI/LO change only in FIX or on reset. No other write path.
- stall_FETCH, combinational:
  - stall_FETCH = busy & (enhilo_EX | regsel_EX != 0).
  - MFHI, MFLO or a new MULT in EX is held until the FIX edge completes.
  - Other instructions proceed while busy; this permits overlap.
- Start while busy: ignored. The request is held by stall_FETCH and accepted in the first IDLE cycle.
  - Back-to-back multiplies therefore start on the edge after FIX.
- A start in the same cycle done is high (IDLE) is accepted normally.
- MFHI/MFLO in the done cycle: no stall; it reads the new HI/LO.
- Operand changes after the start edge have no effect.
- Reset asserted mid-operation:
  - aborts immediately; hi = lo = 0; busy = 0; done = 0.
  - no partial write.
  - after release, state is IDLE and the next start behaves normally.
- done is never high during reset or for more than one consecutive cycle per operation.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 33 cycles hi=0xFFFFFFFE, lo=0x00000001; done pulses once; busy high exactly 33 cycles.
- MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
- MULT 7*6 started, then regsel_EX=2 (MFLO) held from cycle 2 -> stall_FETCH=1 until the FIX edge, 0 in the done cycle where lo=42. regsel_EX=0 while busy -> stall_FETCH=0.
- Two MULTs back-to-back (0x10000*0x10000, then 3*4) -> second held by stall; first gives hi=1, lo=0; second starts the cycle after FIX and gives hi=0, lo=12.
- Reset pulled low at cycle 10 of MULTU 0x1234*0x5678 -> hi=lo=0, busy=0 asynchronously; after release, MULTU 2*3 -> lo=6 after 33 cycles.
- Operands a, b toggled randomly after the start edge of MULTU 0xDEADBEEF*0x2 -> hi=0x1, lo=0xBD5B7DDE, unaffected.

Source files
------------

// File: rtl/hilo_mult_seq.sv
// Multi-cycle MULT/MULTU sequencer for the HI/LO registers.
// Radix-2 shift-add over WIDTH cycles, then one sign-fix cycle that writes HI/LO.
module hilo_mult_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enhilo_EX,
   input  logic             is_signed,
   input  logic [1:0]       regsel_EX,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             stall_FETCH
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] ma;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   mb;
   logic               neg;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic               last;

   // Magnitude of the most negative value wraps to 2^(WIDTH-1), which is correct read unsigned.
   assign abs_a = (is_signed && a[WIDTH-1]) ? -a : a;
   assign abs_b = (is_signed && b[WIDTH-1]) ? -b : b;
   assign last  = (cnt == CW'(WIDTH-1));

   assign busy        = (state != IDLE);
   assign stall_FETCH = busy & (enhilo_EX | (regsel_EX != 2'd0));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (enhilo_EX) state_nxt = CALC;
         CALC:    if (last) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Multiplicand is kept pre-shifted, so acc += ma matches adding ma << cnt.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt  <= '0;
         ma   <= '0;
         mb   <= '0;
         acc  <= '0;
         neg  <= 1'b0;
         hi   <= '0;
         lo   <= '0;
         done <= 1'b0;
      end else begin
         done <= (state == FIX);
         case (state)
            IDLE: begin
               if (enhilo_EX) begin
                  ma  <= {{WIDTH{1'b0}}, abs_a};
                  mb  <= abs_b;
                  neg <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                  acc <= '0;
                  cnt <= '0;
               end
            end
            CALC: begin
               if (mb[0]) acc <= acc + ma;
               ma  <= ma << 1;
               mb  <= mb >> 1;
               cnt <= cnt + CW'(1);
            end
            FIX: begin
               {hi, lo} <= neg ? -acc : acc;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_mult_seq.sv
// Directed bench for hilo_mult_seq: products, latency, stall, back-to-back, reset abort.
module tb_hilo_mult_seq;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         enhilo_EX;
   logic         is_signed;
   logic [1:0]   regsel_EX;
   logic [W-1:0] a, b;
   logic [W-1:0] hi, lo;
   logic         busy, done, stall_FETCH;

   int total = 0;
   int bad   = 0;

   hilo_mult_seq #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .enhilo_EX   (enhilo_EX),
      .is_signed   (is_signed),
      .regsel_EX   (regsel_EX),
      .a           (a),
      .b           (b),
      .hi          (hi),
      .lo          (lo),
      .busy        (busy),
      .done        (done),
      .stall_FETCH (stall_FETCH)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Call just after a rising edge with the DUT idle; the next edge is the start edge.
   task automatic start_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
      enhilo_EX = 1'b1;
      is_signed = s;
      a = x;
      b = y;
      @(posedge clk);
      #1 enhilo_EX = 1'b0;
   endtask

   task automatic wait_done(input bit toggle, output int busy_cycles, output bit seen);
      busy_cycles = 0;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         else if (busy) busy_cycles++;
         if (toggle) begin
            a = $urandom;
            b = $urandom;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_mult(input string tag, input logic s, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic [W-1:0] ehi,
                           input logic [W-1:0] elo, input bit toggle);
      int  bc;
      bit  seen;
      start_op(s, x, y);
      wait_done(toggle, bc, seen);
      check({tag, "_done"}, 64'(seen), 64'd1);
      check({tag, "_busy_cycles"}, 64'(bc), 64'd33);
      check({tag, "_hi"}, 64'(hi), 64'(ehi));
      check({tag, "_lo"}, 64'(lo), 64'(elo));
      check({tag, "_done_once"}, 64'(done), 64'd0);
   endtask

   initial begin
      int  cnt;
      int  bc;
      bit  seen;
      rst = 1'b0;
      enhilo_EX = 1'b0;
      is_signed = 1'b0;
      regsel_EX = 2'd0;
      a = '0;
      b = '0;
      #12;
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_stall", 64'(stall_FETCH), 64'd0);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;

      run_mult("multu_ff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      run_mult("mult_neg", 1'b1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
      run_mult("mult_min", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
      run_mult("toggle", 1'b0, 32'hDEAD_BEEF, 32'd2, 32'h0000_0001, 32'hBD5B_7DDE, 1'b1);

      // MFLO dependency stall
      start_op(1'b1, 32'd7, 32'd6);
      @(negedge clk);
      check("stall_other", 64'(stall_FETCH), 64'd0);
      check("busy_cycle1", 64'(busy), 64'd1);
      @(posedge clk);
      #1 regsel_EX = 2'd2;
      cnt = 0;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         else if (stall_FETCH) cnt++;
      end
      check("mflo_done", 64'(seen), 64'd1);
      check("mflo_stall_cycles", 64'(cnt), 64'd32);
      check("mflo_stall_done", 64'(stall_FETCH), 64'd0);
      check("mflo_lo", 64'(lo), 64'd42);
      check("mflo_hi", 64'(hi), 64'd0);
      @(posedge clk);
      #1 regsel_EX = 2'd0;

      // back-to-back: second request held until the first finishes
      enhilo_EX = 1'b1;
      is_signed = 1'b1;
      a = 32'h0001_0000;
      b = 32'h0001_0000;
      @(posedge clk);
      #1;
      a = 32'd3;
      b = 32'd4;
      cnt = 0;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         else if (stall_FETCH) cnt++;
      end
      check("b2b_first_done", 64'(seen), 64'd1);
      check("b2b_stall_cycles", 64'(cnt), 64'd33);
      check("b2b_first_hi", 64'(hi), 64'd1);
      check("b2b_first_lo", 64'(lo), 64'd0);
      check("b2b_stall_done", 64'(stall_FETCH), 64'd0);
      @(posedge clk);
      #1 enhilo_EX = 1'b0;
      @(negedge clk);
      check("b2b_second_busy", 64'(busy), 64'd1);
      wait_done(1'b0, bc, seen);
      check("b2b_second_done", 64'(seen), 64'd1);
      check("b2b_second_hi", 64'(hi), 64'd0);
      check("b2b_second_lo", 64'(lo), 64'd12);

      // asynchronous reset in the middle of an operation
      start_op(1'b0, 32'h0000_1234, 32'h0000_5678);
      repeat (9) @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_hi", 64'(hi), 64'd0);
      check("abort_lo", 64'(lo), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      @(negedge clk) rst = 1'b1;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || busy) cnt++;
      end
      check("abort_quiet", 64'(cnt), 64'd0);
      check("abort_lo_held", 64'(lo), 64'd0);
      @(posedge clk);
      #1;
      run_mult("after_rst", 1'b0, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
